// File: rtl/branch_predict_tournament.sv
// Tournament branch predictor: per-PC local-history PHT and gshare PHT, arbitrated by a
// per-PC chooser. Counter tables are swept to CTR_INIT after reset before predicting.
module branch_predict_tournament #(
  parameter int         BHT_IDX_W = 10,
  parameter int         LHR_W     = 6,
  parameter int         GHR_W     = 8,
  parameter int         MODE      = 2,
  parameter logic [1:0] CTR_INIT  = 2'd2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flushD,
  input  logic        stallD,
  input  logic [31:0] pcF,
  input  logic [31:0] pcM,
  input  logic        branchM,
  input  logic        actual_takeM,
  input  logic        branchD,
  output logic        pred_takeD,
  output logic        ready
);

  localparam int unsigned BHT_N  = 1 << BHT_IDX_W;
  localparam int unsigned LPHT_N = 1 << LHR_W;
  localparam int unsigned GPHT_N = 1 << GHR_W;
  localparam int          SWP_W  = (LHR_W > GHR_W) ? LHR_W : GHR_W;

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t             state_q, state_d;
  logic [SWP_W-1:0]   sweep_q, sweep_d;
  logic [GHR_W-1:0]   ghr_q, ghr_d;
  logic               dreg_q, dreg_d;
  logic [LHR_W-1:0]   bht_q  [BHT_N];
  logic [1:0]         lpht_q [LPHT_N];
  logic [1:0]         gpht_q [GPHT_N];
  logic [1:0]         chs_q  [GPHT_N];

  logic               update;
  logic               pred_f;
  logic               pc_unused;

  // F-stage lookup
  logic [BHT_IDX_W-1:0] bidx_f;
  logic [LHR_W-1:0]     lh_f;
  logic [GHR_W-1:0]     cidx_f, gidx_f;
  logic                 lp_f, gp_f, ch_f;

  // M-stage lookup (pre-update state)
  logic [BHT_IDX_W-1:0] bidx_m;
  logic [LHR_W-1:0]     lh_m;
  logic [GHR_W-1:0]     cidx_m, gidx_m;
  logic                 lp_m, gp_m;

  // Table write ports
  logic               lp_we, gp_we, ch_we;
  logic [LHR_W-1:0]   lp_wa;
  logic [GHR_W-1:0]   gp_wa, ch_wa;
  logic [1:0]         lp_wd, gp_wd, ch_wd;

  function automatic logic [1:0] sat_step(input logic [1:0] c, input logic up);
    if (up) return (c == 2'd3) ? c : c + 2'd1;
    return (c == 2'd0) ? c : c - 2'd1;
  endfunction

  assign ready     = (state_q == ST_RUN);
  assign update    = ready & branchM;
  assign pc_unused = ^{pcF, pcM};

  assign bidx_f = pcF[BHT_IDX_W+1:2];
  assign lh_f   = bht_q[bidx_f];
  assign cidx_f = pcF[GHR_W+1:2];
  assign gidx_f = cidx_f ^ ghr_q;
  assign lp_f   = lpht_q[lh_f][1];
  assign gp_f   = gpht_q[gidx_f][1];
  assign ch_f   = chs_q[cidx_f][1];

  assign bidx_m = pcM[BHT_IDX_W+1:2];
  assign lh_m   = bht_q[bidx_m];
  assign cidx_m = pcM[GHR_W+1:2];
  assign gidx_m = cidx_m ^ ghr_q;
  assign lp_m   = lpht_q[lh_m][1];
  assign gp_m   = gpht_q[gidx_m][1];

  always_comb begin
    pred_f = 1'b0;
    if (ready) begin
      if (MODE == 0)      pred_f = lp_f;
      else if (MODE == 1) pred_f = gp_f;
      else                pred_f = ch_f ? gp_f : lp_f;
    end
  end

  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    ghr_d   = ghr_q;
    dreg_d  = dreg_q;
    if (state_q == ST_INIT) begin
      sweep_d = sweep_q + SWP_W'(1);
      if (sweep_q == '1) state_d = ST_RUN;
    end
    if (update) ghr_d = {ghr_q[GHR_W-2:0], actual_takeM};
    if (flushD)       dreg_d = 1'b0;
    else if (!stallD) dreg_d = pred_f;
  end

  // INIT sweep and M-stage training share one write port per table.
  always_comb begin
    lp_we = 1'b0;
    gp_we = 1'b0;
    ch_we = 1'b0;
    lp_wa = lh_m;
    gp_wa = gidx_m;
    ch_wa = cidx_m;
    lp_wd = sat_step(lpht_q[lh_m], actual_takeM);
    gp_wd = sat_step(gpht_q[gidx_m], actual_takeM);
    ch_wd = sat_step(chs_q[cidx_m], gp_m == actual_takeM);
    if (state_q == ST_INIT) begin
      lp_we = ({1'b0, sweep_q} < (SWP_W+1)'(LPHT_N));
      gp_we = ({1'b0, sweep_q} < (SWP_W+1)'(GPHT_N));
      ch_we = gp_we;
      lp_wa = sweep_q[LHR_W-1:0];
      gp_wa = sweep_q[GHR_W-1:0];
      ch_wa = sweep_q[GHR_W-1:0];
      lp_wd = CTR_INIT;
      gp_wd = CTR_INIT;
      ch_wd = CTR_INIT;
    end else if (update) begin
      lp_we = 1'b1;
      gp_we = 1'b1;
      ch_we = (lp_m != gp_m);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_INIT;
      sweep_q <= '0;
      ghr_q   <= '0;
      dreg_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
      ghr_q   <= ghr_d;
      dreg_q  <= dreg_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < BHT_N; i++) bht_q[i] <= '0;
    end else if (update) begin
      bht_q[bidx_m] <= {lh_m[LHR_W-2:0], actual_takeM};
    end
  end

  always_ff @(posedge clk) begin
    if (lp_we) lpht_q[lp_wa] <= lp_wd;
    if (gp_we) gpht_q[gp_wa] <= gp_wd;
    if (ch_we) chs_q[ch_wa]  <= ch_wd;
  end

  assign pred_takeD = branchD & dreg_q;

endmodule

// File: tb/tb_branch_predict_tournament.sv
// Bench for branch_predict_tournament: three instances (MODE 0/1/2) share stimulus and are
// checked every cycle against one array-based predictor model plus directed expectations.
module tb_branch_predict_tournament;

  logic        clk, rst, flushD, stallD, branchM, actual_takeM, branchD;
  logic [31:0] pcF, pcM;
  logic        pd0, pd1, pd2, rdy0, rdy1, rdy2;
  logic [2:0]  pd, rdy;

  int tests = 0;
  int fails = 0;

  int lpht [64];
  int gpht [256];
  int chs  [256];
  int bht  [1024];
  int ghr;
  int icnt;
  bit mrdy;
  bit md [3];

  assign pd  = {pd2, pd1, pd0};
  assign rdy = {rdy2, rdy1, rdy0};

  branch_predict_tournament #(.MODE(0)) u_m0 (
    .clk(clk), .rst(rst), .flushD(flushD), .stallD(stallD), .pcF(pcF), .pcM(pcM),
    .branchM(branchM), .actual_takeM(actual_takeM), .branchD(branchD),
    .pred_takeD(pd0), .ready(rdy0));
  branch_predict_tournament #(.MODE(1)) u_m1 (
    .clk(clk), .rst(rst), .flushD(flushD), .stallD(stallD), .pcF(pcF), .pcM(pcM),
    .branchM(branchM), .actual_takeM(actual_takeM), .branchD(branchD),
    .pred_takeD(pd1), .ready(rdy1));
  branch_predict_tournament #(.MODE(2)) u_m2 (
    .clk(clk), .rst(rst), .flushD(flushD), .stallD(stallD), .pcF(pcF), .pcM(pcM),
    .branchM(branchM), .actual_takeM(actual_takeM), .branchD(branchD),
    .pred_takeD(pd2), .ready(rdy2));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mrdy = 1'b0;
    icnt = 0;
    ghr  = 0;
    foreach (bht[i]) bht[i] = 0;
    foreach (md[i]) md[i] = 1'b0;
  endtask

  function automatic bit model_pf(input int m, input logic [31:0] pc);
    int lh, ci, gi;
    bit lp, gp, c;
    if (!mrdy) return 1'b0;
    lh = bht[int'((pc >> 2) & 32'h3FF)];
    ci = int'((pc >> 2) & 32'hFF);
    gi = ci ^ ghr;
    lp = (lpht[lh] >= 2);
    gp = (gpht[gi] >= 2);
    c  = (chs[ci] >= 2);
    if (m == 0) return lp;
    if (m == 1) return gp;
    return c ? gp : lp;
  endfunction

  task automatic model_update(input logic [31:0] pc, input bit t);
    int bi, ci, lh, gi;
    bit lp, gp;
    bi = int'((pc >> 2) & 32'h3FF);
    ci = int'((pc >> 2) & 32'hFF);
    lh = bht[bi];
    gi = ci ^ ghr;
    lp = (lpht[lh] >= 2);
    gp = (gpht[gi] >= 2);
    lpht[lh] = t ? ((lpht[lh] < 3) ? lpht[lh] + 1 : 3) : ((lpht[lh] > 0) ? lpht[lh] - 1 : 0);
    gpht[gi] = t ? ((gpht[gi] < 3) ? gpht[gi] + 1 : 3) : ((gpht[gi] > 0) ? gpht[gi] - 1 : 0);
    if (lp != gp) begin
      if (gp == t) chs[ci] = (chs[ci] < 3) ? chs[ci] + 1 : 3;
      else         chs[ci] = (chs[ci] > 0) ? chs[ci] - 1 : 0;
    end
    bht[bi] = ((lh * 2) + int'(t)) % 64;
    ghr     = ((ghr * 2) + int'(t)) % 256;
  endtask

  // Inputs are driven at the falling edge; outputs checked 1 time unit later.
  task automatic cycle();
    bit pf [3];
    #1;
    for (int m = 0; m < 3; m++) begin
      chk($sformatf("predD_m%0d", m), pd[m], branchD & md[m]);
      chk($sformatf("ready_m%0d", m), rdy[m], mrdy);
      pf[m] = model_pf(m, pcF);
    end
    @(posedge clk);
    if (rst === 1'b1) begin
      for (int m = 0; m < 3; m++) begin
        if (flushD)       md[m] = 1'b0;
        else if (!stallD) md[m] = pf[m];
      end
      if (mrdy && branchM) model_update(pcM, actual_takeM);
      else if (!mrdy) begin
        icnt++;
        if (icnt == 256) begin
          mrdy = 1'b1;
          foreach (lpht[i]) lpht[i] = 2;
          foreach (gpht[i]) gpht[i] = 2;
          foreach (chs[i])  chs[i]  = 2;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic idle();
    flushD = 1'b0; stallD = 1'b0; branchM = 1'b0; branchD = 1'b0;
    actual_takeM = 1'b0; pcM = 32'h0;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (rdy[2] !== 1'b1 && n < 1000) begin
      pcF = $urandom;
      pcM = $urandom;
      branchD = 1'b1;
      branchM = 1'($urandom_range(0, 1));
      actual_takeM = 1'($urandom_range(0, 1));
      cycle();
      n++;
    end
    chki("ready_latency", n, 256);
    idle();
  endtask

  task automatic branch_pair(input logic [31:0] pc, input bit outc, input int m, output bit ok);
    idle();
    pcF = pc;
    cycle();
    branchD = 1'b1; pcF = 32'h0;
    branchM = 1'b1; pcM = pc; actual_takeM = outc;
    #1 ok = (pd[m] === outc);
    cycle();
    idle();
  endtask

  task automatic rand_cycles(input int n);
    logic [31:0] pool [8];
    int bias [8];
    int j;
    for (int i = 0; i < 8; i++) begin
      pool[i] = {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
      bias[i] = $urandom_range(0, 100);
    end
    pool[7] = pool[0] ^ 32'h400;
    for (int i = 0; i < n; i++) begin
      pcF = pool[$urandom_range(0, 7)];
      j = $urandom_range(0, 7);
      pcM = pool[j];
      branchM = 1'($urandom_range(0, 2) != 0);
      actual_takeM = 1'($urandom_range(0, 99) < bias[j]);
      branchD = 1'($urandom_range(0, 1));
      stallD = 1'($urandom_range(0, 7) == 0);
      flushD = 1'($urandom_range(0, 9) == 0);
      cycle();
    end
    idle();
  endtask

  initial begin
    bit ok;
    int good;
    idle();
    pcF = 32'h0;
    rst = 1'b1;
    model_reset();
    #2 rst = 1'b0;
    @(negedge clk);
    repeat (3) cycle();
    rst = 1'b1;
    wait_ready();

    // first prediction after INIT: counters at 2 predict taken
    pcF = 32'h100;
    cycle();
    branchD = 1'b1;
    #1 chk("first_pred_taken", pd[2], 1'b1);
    cycle();
    branchD = 1'b0;
    #1 chk("first_pred_nobranch", pd[2], 1'b0);
    cycle();

    // saturate LPHT[0] downward via pc 0x200
    pcF = 32'h0; branchM = 1'b1; pcM = 32'h200; actual_takeM = 1'b0;
    repeat (3) cycle();
    idle();
    pcF = 32'h200;
    cycle();
    branchD = 1'b1;
    #1;
    chk("sat_pred_m0", pd[0], 1'b0);
    chk("sat_pred_m2", pd[2], 1'b0);
    cycle();

    // stall holds across a PC change; flush wins over stall
    idle();
    pcF = 32'h100;
    cycle();
    stallD = 1'b1; pcF = 32'h200; branchD = 1'b1;
    #1 chk("stall_hold_a", pd[2], 1'b1);
    cycle();
    #1 chk("stall_hold_b", pd[2], 1'b1);
    cycle();
    flushD = 1'b1;
    cycle();
    flushD = 1'b0; stallD = 1'b0;
    #1 chk("flush_over_stall", pd[2], 1'b0);
    cycle();

    // local-history learning of a TTTN loop branch
    good = 0;
    for (int it = 0; it < 40; it++) begin
      for (int k = 0; k < 4; k++) begin
        branch_pair(32'h300, k != 3, 0, ok);
        if (it >= 32 && ok) good++;
      end
    end
    chki("learn_tttn_acc", good, 32);

    // globally correlated pair: B copies A
    good = 0;
    for (int it = 0; it < 50; it++) begin
      branch_pair(32'h400, (it % 2) == 0, 2, ok);
      branch_pair(32'h404, (it % 2) == 0, 2, ok);
      if (it >= 40 && ok) good++;
    end
    chki("tourn_B_acc", good, 10);

    rand_cycles(1500);

    // asynchronous reset mid-run
    pcF = 32'h100; branchD = 1'b1;
    cycle();
    rst = 1'b0;
    #1;
    for (int m = 0; m < 3; m++) begin
      chk($sformatf("async_rst_ready_m%0d", m), rdy[m], 1'b0);
      chk($sformatf("async_rst_pred_m%0d", m), pd[m], 1'b0);
    end
    model_reset();
    repeat (3) cycle();
    rst = 1'b1;
    wait_ready();
    rand_cycles(300);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/branch_predict_tournament.md
Name: branch_predict_tournament

Overview:
- Parametrised successor to the local-history branch predictor; sits beside the fetch/decode stages.
- Combines a per-PC local-history predictor and a gshare (global-history XOR PC) predictor, with a per-PC chooser selecting between them. MODE can force either component alone.
- Predicts at F, registers the prediction into D, and trains at M on resolved branches.
- Tables are initialised by an internal sweep FSM after reset.

Parameters:
- BHT_IDX_W, 10: log2 of local history table entries; indexed by pc[BHT_IDX_W+1:2].
- LHR_W, 6: local history length; log2 of local PHT entries.
- GHR_W, 8: global history length; log2 of global PHT and chooser entries.
- MODE, 2: 0 = local only, 1 = gshare only, 2 = tournament.
- CTR_INIT, 2: initial value of every 2-bit counter (PHTs and chooser).

Ports:
- clk, input, 1: clock, rising edge.
- rst, input, 1: asynchronous, active-low reset.
- flushD, input, 1: clear D-stage prediction register.
- stallD, input, 1: hold D-stage prediction register.
- pcF, input, 32: fetch PC.
- pcM, input, 32: PC of the instruction in M.
- branchM, input, 1: instruction in M is a conditional branch.
- actual_takeM, input, 1: resolved direction of the M branch.
- branchD, input, 1: instruction in D is a conditional branch.
- pred_takeD, output, 1: predicted taken for the D instruction.
- ready, output, 1: tables initialised; predictor active.

Behaviour:
- Counters are 2-bit binary saturating, 0..3. Bit[1]=1 means taken (PHT) or choose gshare (chooser).
- Reset (rst=0, asynchronous):
  - ready=0, pred_takeD=0, D register=0.
  - GHR=0, all BHT local-history registers=0.
  - FSM enters INIT, sweep index=0.
- INIT state:
  - Each cycle, write CTR_INIT to local PHT, global PHT and chooser at the sweep index (indices beyond a table's size are ignored), then increment the index.
  - Lasts exactly 2^max(LHR_W,GHR_W) cycles after rst deasserts, then moves to RUN with ready=1.
  - During INIT, pred_takeF=0 and branchM updates are ignored.
- RUN state: never left except through reset. Reasserting rst mid-run clears the state asynchronously and INIT restarts.
- F-stage prediction (combinational):
  - lh = BHT[pcF[BHT_IDX_W+1:2]]; lp = LPHT[lh][1].
  - gp = GPHT[pcF[GHR_W+1:2] ^ GHR][1].
  - ch = CHOOSER[pcF[GHR_W+1:2]][1].
  - pred_takeF: MODE 0 → lp; MODE 1 → gp; MODE 2 → (ch ? gp : lp). Gated by ready.
- D register:
  - flushD → 0, with priority over stallD.
  - Otherwise stallD → hold.
  - Otherwise load pred_takeF.
- pred_takeD = branchD & D register. One-cycle latency from F.
- M-stage update, only when ready & branchM (no table changes otherwise):
  - Recompute lp_m, gp_m and indices from pcM and the current BHT/GHR, using pre-update values.
  - LPHT[old lh] and GPHT[old gidx]: +1 if taken, −1 if not, saturating at 3/0.
  - BHT entry ← {old lh[LHR_W-2:0], actual_takeM}; GHR ← {GHR[GHR_W-2:0], actual_takeM}.
  - Chooser at pcM index changes only if lp_m != gp_m: +1 (saturating) if gp_m == actual_takeM, else −1 (saturating).
  - All tables are updated in every MODE.
- Same-cycle F read and M write to the same entry: F sees the old value; the new value is visible the next cycle.
- Width rules: GHR_W+1 ≤ 31 and BHT_IDX_W+1 ≤ 31; index bits above pc[31] are never used. LHR_W ≥ 2 and GHR_W ≥ 2.

Test Plan:
- Reset/INIT: assert rst=0 for 3 cycles then release → ready rises exactly 256 cycles later (default parameters). pred_takeD=0 throughout INIT even with branchD=1.
- First prediction, MODE=2, after ready: pcF=0x100 with branchD=1 next cycle → pred_takeD=1 (CTR_INIT=2). With branchD=0 → pred_takeD=0.
- Saturation, MODE=0: three branchM=1/actual_takeM=0 updates at pcM=0x200 → LPHT[0] goes 2→1→0→0. Fetch at 0x200 predicts 0. BHT entry stays 0.
- Learning, MODE=0: repeated loop outcome TTTN at pc 0x300 for 40 iterations → last 8 iterations predicted with 100% accuracy.
- Tournament, MODE=2: global-correlated pattern (branch A at 0x400 alternates T/N; branch B at 0x404 copies A) for 50 iterations → B's chooser counter saturates to 3, and B's predictions are all correct in the last 10 iterations.
- Pipeline and reset: stallD=1 holds pred_takeD across a pcF change; flushD=1 with stallD=1 gives pred_takeD=0 next cycle. rst dropped mid-run gives ready=0 and pred_takeD=0 immediately, without a clock edge.
